// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout and default datapath sizes.
// Every pipeline stage decodes instructions through these constants.
package cpu_pkg;

  localparam int INSTR_W        = 32;
  localparam int OPCODE_W       = 4;
  localparam int IMM_W          = 16;
  localparam int CPU_DATA_WIDTH = 32;
  localparam int CPU_REG_AW     = 4;

  // Low bit of each field inside the instruction word.
  localparam int OPCODE_LSB = 28;
  localparam int RD_LSB     = 24;
  localparam int RS1_LSB    = 20;
  localparam int RS2_LSB    = 16;
  localparam int IMM_LSB    = 0;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_LSB +: OPCODE_W];
  endfunction

  function automatic logic [IMM_W-1:0] get_imm(input logic [INSTR_W-1:0] instr);
    return instr[IMM_LSB +: IMM_W];
  endfunction

endpackage

// File: rtl/forward_mux.sv
// Per-source operand selector: EX bypass, then WB bypass, then register file.
// A load still in EX has no data yet, so it never forwards from this stage.
module forward_mux
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int REG_AW     = CPU_REG_AW
) (
  input  logic [REG_AW-1:0]     rs,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  ex_we,
  input  logic [REG_AW-1:0]     ex_ws,
  input  logic [DATA_WIDTH-1:0] ex_wd,
  input  logic                  ex_is_load,
  input  logic                  wb_we,
  input  logic [REG_AW-1:0]     wb_ws,
  input  logic [DATA_WIDTH-1:0] wb_wd,
  output logic [DATA_WIDTH-1:0] operand
);

  logic ex_hit;
  logic wb_hit;

  assign ex_hit = ex_we && (ex_ws == rs) && !ex_is_load;
  assign wb_hit = wb_we && (wb_ws == rs);

  always_comb begin
    operand = rf_data;
    if (ex_hit) begin
      operand = ex_wd;
    end else if (wb_hit) begin
      operand = wb_wd;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads register sources, applies bypassing, detects
// load-use hazards and registers the decoded instruction behind a valid/ready skid.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int REG_AW     = CPU_REG_AW
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [INSTR_W-1:0]    i_instr,
  output logic                  o_ready,
  output logic [REG_AW-1:0]     o_rs1,
  output logic [REG_AW-1:0]     o_rs2,
  input  logic [DATA_WIDTH-1:0] i_rd1,
  input  logic [DATA_WIDTH-1:0] i_rd2,
  input  logic                  i_ex_we,
  input  logic [REG_AW-1:0]     i_ex_ws,
  input  logic [DATA_WIDTH-1:0] i_ex_wd,
  input  logic                  i_ex_is_load,
  input  logic                  i_wb_we,
  input  logic [REG_AW-1:0]     i_wb_ws,
  input  logic [DATA_WIDTH-1:0] i_wb_wd,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [OPCODE_W-1:0]   o_opcode,
  output logic [REG_AW-1:0]     o_rd,
  output logic [DATA_WIDTH-1:0] o_op1,
  output logic [DATA_WIDTH-1:0] o_op2,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [15:0]           o_stall_cycles
);

  logic [DATA_WIDTH-1:0] op1_sel;
  logic [DATA_WIDTH-1:0] op2_sel;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [IMM_W-1:0]      imm_raw;
  logic [REG_AW-1:0]     rd_dec;
  logic                  hazard;
  logic                  capture;

  assign o_rs1   = i_instr[RS1_LSB +: REG_AW];
  assign o_rs2   = i_instr[RS2_LSB +: REG_AW];
  assign rd_dec  = i_instr[RD_LSB +: REG_AW];
  assign imm_raw = get_imm(i_instr);
  assign imm_ext = {{(DATA_WIDTH-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};

  forward_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs         (o_rs1),
    .rf_data    (i_rd1),
    .ex_we      (i_ex_we),
    .ex_ws      (i_ex_ws),
    .ex_wd      (i_ex_wd),
    .ex_is_load (i_ex_is_load),
    .wb_we      (i_wb_we),
    .wb_ws      (i_wb_ws),
    .wb_wd      (i_wb_wd),
    .operand    (op1_sel)
  );

  forward_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs         (o_rs2),
    .rf_data    (i_rd2),
    .ex_we      (i_ex_we),
    .ex_ws      (i_ex_ws),
    .ex_wd      (i_ex_wd),
    .ex_is_load (i_ex_is_load),
    .wb_we      (i_wb_we),
    .wb_ws      (i_wb_ws),
    .wb_wd      (i_wb_wd),
    .operand    (op2_sel)
  );

  // A load in EX cannot be forwarded; hold the consumer until it reaches WB.
  assign hazard  = i_valid && i_ex_we && i_ex_is_load &&
                   ((i_ex_ws == o_rs1) || (i_ex_ws == o_rs2));
  assign o_ready = (!o_valid || i_ready) && !hazard;
  assign capture = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid  <= 1'b0;
      o_opcode <= '0;
      o_rd     <= '0;
      o_op1    <= '0;
      o_op2    <= '0;
      o_imm    <= '0;
    end else if (capture) begin
      o_valid  <= 1'b1;
      o_opcode <= get_opcode(i_instr);
      o_rd     <= rd_dec;
      o_op1    <= op1_sel;
      o_op2    <= op2_sel;
      o_imm    <= imm_ext;
    end else if (o_valid && i_ready) begin
      o_valid  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_cycles <= '0;
    end else if (hazard && (o_stall_cycles != 16'hFFFF)) begin
      o_stall_cycles <= o_stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch with a small register-file model.
module tb_operand_fetch;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_instr;
  logic        o_ready;
  logic [3:0]  o_rs1, o_rs2;
  logic [31:0] i_rd1, i_rd2;
  logic        i_ex_we, i_ex_is_load;
  logic [3:0]  i_ex_ws;
  logic [31:0] i_ex_wd;
  logic        i_wb_we;
  logic [3:0]  i_wb_ws;
  logic [31:0] i_wb_wd;
  logic        o_valid;
  logic        i_ready;
  logic [3:0]  o_opcode, o_rd;
  logic [31:0] o_op1, o_op2, o_imm;
  logic [15:0] o_stall_cycles;

  logic [31:0] rf [16];
  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  assign i_rd1 = rf[o_rs1];
  assign i_rd2 = rf[o_rs2];

  operand_fetch dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_instr(i_instr),
    .o_ready(o_ready), .o_rs1(o_rs1), .o_rs2(o_rs2), .i_rd1(i_rd1), .i_rd2(i_rd2),
    .i_ex_we(i_ex_we), .i_ex_ws(i_ex_ws), .i_ex_wd(i_ex_wd), .i_ex_is_load(i_ex_is_load),
    .i_wb_we(i_wb_we), .i_wb_ws(i_wb_ws), .i_wb_wd(i_wb_wd),
    .o_valid(o_valid), .i_ready(i_ready), .o_opcode(o_opcode), .o_rd(o_rd),
    .o_op1(o_op1), .o_op2(o_op2), .o_imm(o_imm), .o_stall_cycles(o_stall_cycles)
  );

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr);
    i_valid = valid;
    i_instr = instr;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h100 + i;
    rf[2] = 32'd5;
    rf[3] = 32'd7;
    i_reset = 1'b1; i_ready = 1'b1;
    i_ex_we = 1'b0; i_ex_ws = '0; i_ex_wd = '0; i_ex_is_load = 1'b0;
    i_wb_we = 1'b0; i_wb_ws = '0; i_wb_wd = '0;
    applyStimulus(1'b0, 32'h0);
    tick(); tick();
    checkOutput("reset_valid", o_valid, 0);
    checkOutput("reset_op1", o_op1, 0);
    checkOutput("reset_imm", o_imm, 0);
    checkOutput("reset_opcode", o_opcode, 0);
    checkOutput("reset_stall", o_stall_cycles, 0);
    i_reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", o_ready, 1);

    // Plain register-file operands
    applyStimulus(1'b1, mk(4'h1, 4'h4, 4'h2, 4'h3, 16'h0010));
    #1;
    checkOutput("rs1_addr", o_rs1, 2);
    checkOutput("rs2_addr", o_rs2, 3);
    tick();
    checkOutput("basic_valid", o_valid, 1);
    checkOutput("basic_op1", o_op1, 5);
    checkOutput("basic_op2", o_op2, 7);
    checkOutput("basic_opcode", o_opcode, 1);
    checkOutput("basic_rd", o_rd, 4);
    checkOutput("basic_imm", o_imm, 32'h10);
    applyStimulus(1'b0, 32'h0);
    tick();
    checkOutput("bubble_valid", o_valid, 0);

    // EX beats WB on the same source; rs1==rs2 gives identical operands
    i_ex_we = 1'b1; i_ex_ws = 4'd2; i_ex_wd = 32'hAA;
    i_wb_we = 1'b1; i_wb_ws = 4'd2; i_wb_wd = 32'hBB;
    applyStimulus(1'b1, mk(4'h2, 4'h1, 4'h2, 4'h2, 16'h0));
    tick();
    checkOutput("ex_prio_op1", o_op1, 32'hAA);
    checkOutput("ex_prio_op2", o_op2, 32'hAA);
    i_ex_we = 1'b0;
    applyStimulus(1'b1, mk(4'h3, 4'h1, 4'h2, 4'h5, 16'h0));
    tick();
    checkOutput("wb_op1", o_op1, 32'hBB);
    checkOutput("wb_op2", o_op2, 32'h105);
    i_wb_we = 1'b0;
    applyStimulus(1'b0, 32'h0);
    tick();
    checkOutput("drain_valid", o_valid, 0);

    // Load-use hazard held for three cycles
    i_ex_we = 1'b1; i_ex_is_load = 1'b1; i_ex_ws = 4'd3; i_ex_wd = 32'hDEAD;
    applyStimulus(1'b1, mk(4'h4, 4'h6, 4'h1, 4'h3, 16'h0));
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("hazard_ready", o_ready, 0);
      tick();
      checkOutput("hazard_valid", o_valid, 0);
    end
    checkOutput("stall_count", o_stall_cycles, 3);
    i_ex_we = 1'b0; i_ex_is_load = 1'b0;
    #1;
    checkOutput("post_hazard_ready", o_ready, 1);
    tick();
    checkOutput("post_hazard_valid", o_valid, 1);
    checkOutput("post_hazard_op1", o_op1, 32'h101);
    checkOutput("post_hazard_op2", o_op2, 7);
    applyStimulus(1'b0, 32'h0);
    tick();
    checkOutput("consumed_valid", o_valid, 0);
    checkOutput("stall_hold", o_stall_cycles, 3);

    // Downstream backpressure holds outputs despite bypass activity
    applyStimulus(1'b1, mk(4'h5, 4'h6, 4'h4, 4'h2, 16'h0));
    tick();
    checkOutput("hold_cap_op1", o_op1, 32'h104);
    i_ready = 1'b0;
    applyStimulus(1'b1, mk(4'h9, 4'h7, 4'h4, 4'h4, 16'h1234));
    for (int c = 0; c < 3; c++) begin
      i_wb_we = c[0] ? 1'b0 : 1'b1; i_wb_ws = 4'd4; i_wb_wd = 32'h500 + c;
      #1;
      checkOutput("hold_ready", o_ready, 0);
      tick();
      checkOutput("hold_valid", o_valid, 1);
      checkOutput("hold_opcode", o_opcode, 5);
      checkOutput("hold_op1", o_op1, 32'h104);
      checkOutput("hold_op2", o_op2, 5);
    end
    i_wb_we = 1'b0;
    i_ready = 1'b1;
    #1;
    checkOutput("release_ready", o_ready, 1);
    tick();
    checkOutput("release_opcode", o_opcode, 9);
    checkOutput("release_op2", o_op2, 32'h104);

    // Immediate sign extension, back-to-back captures
    applyStimulus(1'b1, mk(4'h6, 4'h0, 4'h0, 4'h0, 16'h8001));
    tick();
    checkOutput("imm_neg", o_imm, 32'hFFFF8001);
    applyStimulus(1'b1, mk(4'h7, 4'h0, 4'h0, 4'h0, 16'h7FFF));
    tick();
    checkOutput("imm_pos", o_imm, 32'h00007FFF);
    checkOutput("b2b_valid", o_valid, 1);
    checkOutput("b2b_opcode", o_opcode, 7);

    // Reset while an instruction is held
    i_ready = 1'b0;
    applyStimulus(1'b0, 32'h0);
    tick();
    checkOutput("pre_reset_valid", o_valid, 1);
    i_reset = 1'b1;
    tick();
    checkOutput("midreset_valid", o_valid, 0);
    checkOutput("midreset_stall", o_stall_cycles, 0);
    checkOutput("midreset_imm", o_imm, 0);
    i_reset = 1'b0;
    #1;
    checkOutput("midreset_ready", o_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning operand and register data width.
REQ-002 The block SHALL have parameter REG_AW, default 4, meaning register address width (16 registers).
REQ-003 The block SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port i_valid  input  1  upstream instruction valid.
REQ-006 The block SHALL have port i_instr  input  32  instruction: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm.
REQ-007 The block SHALL have port o_ready  output  1  block accepts i_instr this cycle.
REQ-008 The block SHALL have ports o_rs1, o_rs2  output  REG_AW  combinational register-file read addresses.
REQ-009 The block SHALL have ports i_rd1, i_rd2  input  DATA_WIDTH  combinational register-file read data.
REQ-010 The block SHALL have ports i_ex_we  input  1, i_ex_ws  input  REG_AW, i_ex_wd  input  DATA_WIDTH, i_ex_is_load  input  1  execute-stage result bypass.
REQ-011 The block SHALL have ports i_wb_we  input  1, i_wb_ws  input  REG_AW, i_wb_wd  input  DATA_WIDTH  writeback bypass; same signals drive the register-file write port.
REQ-012 The block SHALL have ports o_valid  output  1  and i_ready  input  1  downstream valid/ready handshake.
REQ-013 The block SHALL have ports o_opcode  output  4, o_rd  output  REG_AW, o_op1/o_op2  output  DATA_WIDTH, o_imm  output  DATA_WIDTH  registered decoded instruction.
REQ-014 The block SHALL have port o_stall_cycles  output  16  saturating count of load-use stall cycles.

Function
REQ-015 o_rs1/o_rs2 SHALL equal i_instr[23:20]/[19:16] combinationally, regardless of i_valid.
REQ-016 Operand selection per source SHALL be, in priority: EX bypass when i_ex_we and i_ex_ws==rs and not i_ex_is_load; else WB bypass when i_wb_we and i_wb_ws==rs; else i_rdN.
REQ-017 Hazard SHALL assert when i_valid and i_ex_we and i_ex_is_load and i_ex_ws equals rs1 or rs2.
REQ-018 o_ready SHALL equal (!o_valid || i_ready) && !hazard.
REQ-019 On a cycle with i_valid && o_ready, output registers SHALL capture opcode, rd, selected operands, and imm sign-extended from bit 15; o_valid SHALL be 1 next cycle.
REQ-020 When o_valid && i_ready and no capture occurs, o_valid SHALL clear next cycle (bubble); output data may hold stale values.
REQ-021 When o_valid && !i_ready, all output registers SHALL hold unchanged; bypass updates SHALL NOT alter held operands.
REQ-022 Latency SHALL be one cycle from accepted instruction to o_valid; sustained throughput one instruction per cycle with i_ready high and no hazard.
REQ-023 o_stall_cycles SHALL increment by 1 each cycle hazard is asserted and SHALL saturate at 16'hFFFF.
REQ-024 Simultaneous EX and WB matches on the same source SHALL select EX; rs1==rs2 SHALL yield identical operands.

Reset
REQ-025 With i_reset high at a rising edge, o_valid SHALL become 0, o_opcode/o_rd/o_op1/o_op2/o_imm 0, o_stall_cycles 0.
REQ-026 Reset mid-operation SHALL discard any held instruction; o_ready SHALL be combinationally valid in the cycle after reset releases.

Structure
REQ-027 A shared package cpu_pkg SHALL hold instruction field positions, opcode width, REG_AW and DATA_WIDTH defaults.
REQ-028 Operand bypass selection SHALL be one sub-module forward_mux, instantiated once per source.

Verification
REQ-029 Reset, then instr rs1=2 rs2=3, i_rd1=5, i_rd2=7, no bypass -> next cycle o_valid=1, o_op1=5, o_op2=7.
REQ-030 EX bypass ws=2 wd=0xAA, WB bypass ws=2 wd=0xBB, rs1=2 -> o_op1=0xAA.
REQ-031 EX load ws=3 held 3 cycles, instr rs2=3 -> o_ready=0 for 3 cycles, o_stall_cycles=3, o_valid drops after consumed.
REQ-032 i_ready=0 with o_valid=1, new i_valid, WB bypass toggling -> outputs unchanged, o_ready=0.
REQ-033 imm=0x8001 -> o_imm=0xFFFF8001; imm=0x7FFF -> o_imm=0x00007FFF.
REQ-034 i_reset asserted while o_valid=1 and i_ready=0 -> next cycle o_valid=0, o_stall_cycles=0.
